// File: rtl/seq_pkg.sv
// Shared definitions for the microprogram sequencer: opcodes, default width
// and the next-address source selector.
package seq_pkg;

  localparam int WIDTH_DEFAULT = 12;

  // AM2910-style instruction opcodes
  localparam logic [3:0] OP_JZ   = 4'd0;
  localparam logic [3:0] OP_CJS  = 4'd1;
  localparam logic [3:0] OP_JMAP = 4'd2;
  localparam logic [3:0] OP_CJP  = 4'd3;
  localparam logic [3:0] OP_PUSH = 4'd4;
  localparam logic [3:0] OP_JSRP = 4'd5;
  localparam logic [3:0] OP_CJV  = 4'd6;
  localparam logic [3:0] OP_JRP  = 4'd7;
  localparam logic [3:0] OP_RFCT = 4'd8;
  localparam logic [3:0] OP_RPCT = 4'd9;
  localparam logic [3:0] OP_CRTN = 4'd10;
  localparam logic [3:0] OP_CJPP = 4'd11;
  localparam logic [3:0] OP_LDCT = 4'd12;
  localparam logic [3:0] OP_LOOP = 4'd13;
  localparam logic [3:0] OP_CONT = 4'd14;
  localparam logic [3:0] OP_TWB  = 4'd15;

  // Next-address source: direct data, uPC, register/counter, stack top (F), zero
  typedef enum logic [2:0] {YS_D, YS_UPC, YS_R, YS_F, YS_ZERO} ysel_e;

endpackage

// File: rtl/seq_regcnt.sv
// Register/counter R: loadable, decrements toward zero and holds there.
module seq_regcnt
  import seq_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic             decrement,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] r,
  output logic             zero
);

  assign zero = (r == '0);

  // Load wins over decrement; decrement saturates at zero.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      r <= '0;
    else if (load)
      r <= d;
    else if (decrement && !zero)
      r <= r - 1'b1;
  end

endmodule

// File: rtl/seq_ctrl.sv
// Next-address controller for the microprogram sequencer. Decodes the
// instruction and condition, selects Y, drives the stack controls and keeps
// the uPC and the sticky stack-error flag.
module seq_ctrl
  import seq_pkg::*;
#(
  parameter int          WIDTH      = WIDTH_DEFAULT,
  parameter int unsigned RESET_ADDR = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [3:0]       instr,
  input  logic             cc_n,
  input  logic             ccen_n,
  input  logic             ci,
  input  logic             rld_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] y,
  output logic             pl_n,
  output logic             map_n,
  output logic             vect_n,
  output logic             stk_push_en,
  output logic             stk_pop_en,
  output logic             stk_clear_en,
  output logic [WIDTH-1:0] stk_data_in,
  input  logic [WIDTH-1:0] stk_top,
  input  logic             stk_full,
  input  logic             stk_empty,
  output logic             stk_err
);

  logic [WIDTH-1:0] upc;
  logic [WIDTH-1:0] r;
  logic             r_zero;
  logic             pass;
  ysel_e            ysel;
  logic             push_req;
  logic             pop_req;
  logic             clear_req;
  logic             r_ld_dec;
  logic             r_dec;
  logic             blocked;

  assign pass = ccen_n | ~cc_n;

  // Instruction decode: Y source, stack request, R action and source strobes.
  // NOTE: every output gets a default first so no path leaves a latch behind.
  always_comb begin
    ysel      = YS_UPC;
    push_req  = 1'b0;
    pop_req   = 1'b0;
    clear_req = 1'b0;
    r_ld_dec  = 1'b0;
    r_dec     = 1'b0;
    pl_n      = 1'b0;
    map_n     = 1'b1;
    vect_n    = 1'b1;
    case (instr)
      OP_JZ: begin
        ysel      = YS_ZERO;
        clear_req = 1'b1;
      end
      OP_CJS: begin
        if (pass) begin
          ysel     = YS_D;
          push_req = 1'b1;
        end
      end
      OP_JMAP: begin
        ysel  = YS_D;
        pl_n  = 1'b1;
        map_n = 1'b0;
      end
      OP_CJP: begin
        if (pass) ysel = YS_D;
      end
      OP_PUSH: begin
        push_req = 1'b1;
        r_ld_dec = pass;
      end
      OP_JSRP: begin
        ysel     = pass ? YS_D : YS_R;
        push_req = 1'b1;
      end
      OP_CJV: begin
        if (pass) ysel = YS_D;
        pl_n   = 1'b1;
        vect_n = 1'b0;
      end
      OP_JRP: begin
        ysel = pass ? YS_D : YS_R;
      end
      OP_RFCT: begin
        if (!r_zero) begin
          ysel  = YS_F;
          r_dec = 1'b1;
        end else begin
          pop_req = 1'b1;
        end
      end
      OP_RPCT: begin
        if (!r_zero) begin
          ysel  = YS_D;
          r_dec = 1'b1;
        end
      end
      OP_CRTN: begin
        if (pass) begin
          ysel    = YS_F;
          pop_req = 1'b1;
        end
      end
      OP_CJPP: begin
        if (pass) begin
          ysel    = YS_D;
          pop_req = 1'b1;
        end
      end
      OP_LDCT: begin
        r_ld_dec = 1'b1;
      end
      OP_LOOP: begin
        if (pass) pop_req = 1'b1;
        else      ysel    = YS_F;
      end
      OP_CONT: begin
        ysel = YS_UPC;
      end
      OP_TWB: begin
        if (pass) begin
          pop_req = 1'b1;
        end else if (!r_zero) begin
          ysel  = YS_F;
          r_dec = 1'b1;
        end else begin
          ysel    = YS_D;
          pop_req = 1'b1;
        end
      end
      default: ysel = YS_UPC;
    endcase
  end

  // Next-address multiplexer
  always_comb begin
    case (ysel)
      YS_D:    y = d;
      YS_UPC:  y = upc;
      YS_R:    y = r;
      YS_F:    y = stk_top;
      YS_ZERO: y = '0;
      default: y = upc;
    endcase
  end

  // Stack requests are gated by status and forced off while in reset.
  assign stk_push_en  = push_req & ~stk_full & reset_n;
  assign stk_pop_en   = pop_req & ~stk_empty & reset_n;
  assign stk_clear_en = clear_req & reset_n;
  assign stk_data_in  = upc;
  assign blocked      = (push_req & stk_full) | (pop_req & stk_empty);

  // Microprogram counter: next address plus carry-in, wrapping at 2^WIDTH.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      upc <= WIDTH'(RESET_ADDR);
    else
      upc <= y + WIDTH'(ci);
  end

  // Sticky stack-error flag; a stack clear wipes it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      stk_err <= 1'b0;
    else if (clear_req)
      stk_err <= 1'b0;
    else if (blocked)
      stk_err <= 1'b1;
  end

  // External rld_n load takes priority over any decode-driven R action.
  seq_regcnt #(.WIDTH(WIDTH)) u_regcnt (
    .clk       (clk),
    .reset_n   (reset_n),
    .load      (~rld_n | r_ld_dec),
    .decrement (r_dec),
    .d         (d),
    .r         (r),
    .zero      (r_zero)
  );

endmodule
